// File: rtl/csr_pkg.sv
// Shared CSR addresses, writable-field masks and reset values for csr_file.
package csr_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_CRMD   = 14'h000;
    localparam logic [ADDR_W-1:0] ADDR_PRMD   = 14'h001;
    localparam logic [ADDR_W-1:0] ADDR_ECFG   = 14'h004;
    localparam logic [ADDR_W-1:0] ADDR_ESTAT  = 14'h005;
    localparam logic [ADDR_W-1:0] ADDR_ERA    = 14'h006;
    localparam logic [ADDR_W-1:0] ADDR_EENTRY = 14'h00C;
    localparam logic [ADDR_W-1:0] ADDR_SAVE0  = 14'h030;
    localparam logic [ADDR_W-1:0] ADDR_TID    = 14'h040;
    localparam logic [ADDR_W-1:0] ADDR_TCFG   = 14'h041;
    localparam logic [ADDR_W-1:0] ADDR_TVAL   = 14'h042;
    localparam logic [ADDR_W-1:0] ADDR_TICLR  = 14'h044;

    // Software-writable bits of each CSR
    localparam logic [DATA_W-1:0] WMASK_CRMD   = 32'h0000_01FF;
    localparam logic [DATA_W-1:0] WMASK_PRMD   = 32'h0000_0007;
    localparam logic [DATA_W-1:0] WMASK_ECFG   = 32'h0000_1BFF;
    localparam logic [DATA_W-1:0] WMASK_ESTAT  = 32'h0000_0003;
    localparam logic [DATA_W-1:0] WMASK_EENTRY = 32'hFFFF_FFC0;
    localparam logic [DATA_W-1:0] WMASK_ALL    = 32'hFFFF_FFFF;

    localparam int unsigned CRMD_IE      = 2;
    localparam int unsigned MODE_W       = 3;
    localparam int unsigned IS_W         = 13;
    localparam int unsigned ESTAT_IS_TI  = 11;
    localparam int unsigned TCFG_EN      = 0;
    localparam int unsigned TCFG_PERIOD  = 1;
    localparam int unsigned TICLR_CLR    = 0;

    localparam logic [DATA_W-1:0] CRMD_RST = 32'h0000_0008;

    function automatic logic [DATA_W-1:0] csr_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] data,
        input logic [DATA_W-1:0] mask,
        input logic [DATA_W-1:0] wmask
    );
        logic [DATA_W-1:0] m;
        m = mask & wmask;
        return (old_v & ~m) | (data & m);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Countdown timer: TCFG register, TVAL counter and a one-cycle expiry indication.
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tcfg_we,
    input  logic [31:0] i_tcfg_wdata,
    output logic [31:0] o_tcfg,
    output logic [31:0] o_tval,
    output logic        o_expire_c
);

    logic [31:0] r_tcfg;
    logic [31:0] r_tval;
    logic [31:0] w_reload_new;
    logic [31:0] w_reload_cur;

    assign w_reload_new = {i_tcfg_wdata[31:2], 2'b00};
    assign w_reload_cur = {r_tcfg[31:2], 2'b00};
    assign o_expire_c   = r_tcfg[TCFG_EN] && (r_tval == 32'd1);

    // A TCFG write reloads the counter even on the cycle it would expire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcfg <= '0;
            r_tval <= '0;
        end else if (i_tcfg_we) begin
            r_tcfg <= i_tcfg_wdata;
            r_tval <= w_reload_new;
        end else if (o_expire_c) begin
            r_tval <= r_tcfg[TCFG_PERIOD] ? w_reload_cur : 32'd0;
        end else if (r_tcfg[TCFG_EN] && (r_tval != 32'd0)) begin
            r_tval <= r_tval - 32'd1;
        end
    end

    assign o_tcfg = r_tcfg;
    assign o_tval = r_tval;

endmodule

// File: rtl/csr_file.sv
// Privileged CSR file: mode/exception CSRs, SAVE scratch registers and an optional timer.
// Timer CSRs (TID/TCFG/TVAL/TICLR, ESTAT.IS[11]) exist only when CSR_TIMER_EN is defined.
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned SAVE_NUM = 4,
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] i_rd_addr,
    output logic [31:0] o_rd_data,
    input  logic        i_wr_en,
    input  logic [13:0] i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_wr_mask,
    input  logic        i_ex_valid,
    input  logic [5:0]  i_ex_ecode,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ertn_valid,
    input  logic [7:0]  i_hw_int,
    output logic [31:0] o_ex_entry,
    output logic [31:0] o_ertn_pc,
    output logic [1:0]  o_cur_plv,
    output logic        o_int_pending
);

    logic [31:0] r_crmd;
    logic [31:0] r_prmd;
    logic [31:0] r_ecfg;
    logic [31:0] r_era;
    logic [31:0] r_eentry;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic [5:0]  r_ecode;
    logic [31:0] r_save [SAVE_NUM];

    logic        w_ertn;
    logic        w_wr_crmd;
    logic        w_wr_prmd;
    logic        w_wr_ecfg;
    logic        w_wr_estat;
    logic        w_wr_era;
    logic        w_wr_eentry;
    logic [1:0]  w_is_sw_mask;
    logic        w_is_ti;
    logic [31:0] w_estat;
    logic [31:0] w_tid;
    logic [31:0] w_tcfg;
    logic [31:0] w_tval;
    logic [31:0] w_save_rd;
    logic [31:0] w_rd_data;

    assign w_ertn      = i_ertn_valid && !i_ex_valid;
    assign w_wr_crmd   = i_wr_en && (i_wr_addr == ADDR_CRMD);
    assign w_wr_prmd   = i_wr_en && (i_wr_addr == ADDR_PRMD);
    assign w_wr_ecfg   = i_wr_en && (i_wr_addr == ADDR_ECFG);
    assign w_wr_estat  = i_wr_en && (i_wr_addr == ADDR_ESTAT);
    assign w_wr_era    = i_wr_en && (i_wr_addr == ADDR_ERA);
    assign w_wr_eentry = i_wr_en && (i_wr_addr == ADDR_EENTRY);
    assign w_is_sw_mask = i_wr_mask[1:0] & WMASK_ESTAT[1:0];

    // Exception entry beats ertn, and both beat a software write to the CSRs they update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crmd <= CRMD_RST;
        end else if (i_ex_valid) begin
            r_crmd <= {r_crmd[31:MODE_W], 3'b000};
        end else if (w_ertn) begin
            r_crmd <= {r_crmd[31:MODE_W], r_prmd[MODE_W-1:0]};
        end else if (w_wr_crmd) begin
            r_crmd <= csr_merge(r_crmd, i_wr_data, i_wr_mask, WMASK_CRMD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prmd <= '0;
            r_era  <= '0;
        end else if (i_ex_valid) begin
            r_prmd <= {r_prmd[31:MODE_W], r_crmd[MODE_W-1:0]};
            r_era  <= i_ex_pc;
        end else begin
            if (w_wr_prmd) begin
                r_prmd <= csr_merge(r_prmd, i_wr_data, i_wr_mask, WMASK_PRMD);
            end
            if (w_wr_era) begin
                r_era <= csr_merge(r_era, i_wr_data, i_wr_mask, WMASK_ALL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ecfg   <= '0;
            r_eentry <= '0;
        end else begin
            if (w_wr_ecfg) begin
                r_ecfg <= csr_merge(r_ecfg, i_wr_data, i_wr_mask, WMASK_ECFG);
            end
            if (w_wr_eentry) begin
                r_eentry <= csr_merge(r_eentry, i_wr_data, i_wr_mask, WMASK_EENTRY);
            end
        end
    end

    // ESTAT: hardware lines are resampled every cycle, SW bits and Ecode as written
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_sw <= '0;
            r_is_hw <= '0;
            r_ecode <= '0;
        end else begin
            r_is_hw <= i_hw_int;
            if (i_ex_valid) begin
                r_ecode <= i_ex_ecode;
            end else if (w_wr_estat) begin
                r_is_sw <= (r_is_sw & ~w_is_sw_mask) | (i_wr_data[1:0] & w_is_sw_mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SAVE_NUM; i++) begin
                r_save[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int unsigned i = 0; i < SAVE_NUM; i++) begin
                if (i_wr_addr == ADDR_SAVE0 + 14'(i)) begin
                    r_save[i] <= csr_merge(r_save[i], i_wr_data, i_wr_mask, WMASK_ALL);
                end
            end
        end
    end

`ifdef CSR_TIMER_EN
    logic [31:0] r_tid;
    logic        r_is_ti;
    logic        w_tcfg_we;
    logic [31:0] w_tcfg_new;
    logic        w_expire;
    logic        w_ticlr_clr;

    assign w_tcfg_we   = i_wr_en && (i_wr_addr == ADDR_TCFG);
    assign w_tcfg_new  = csr_merge(w_tcfg, i_wr_data, i_wr_mask, WMASK_ALL);
    assign w_ticlr_clr = i_wr_en && (i_wr_addr == ADDR_TICLR)
                         && i_wr_data[TICLR_CLR] && i_wr_mask[TICLR_CLR];

    csr_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_tcfg_we    (w_tcfg_we),
        .i_tcfg_wdata (w_tcfg_new),
        .o_tcfg       (w_tcfg),
        .o_tval       (w_tval),
        .o_expire_c   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tid <= TID_INIT;
        end else if (i_wr_en && (i_wr_addr == ADDR_TID)) begin
            r_tid <= csr_merge(r_tid, i_wr_data, i_wr_mask, WMASK_ALL);
        end
    end

    // Expiry set takes precedence over a same-cycle TICLR clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_ti <= 1'b0;
        end else if (w_expire) begin
            r_is_ti <= 1'b1;
        end else if (w_ticlr_clr) begin
            r_is_ti <= 1'b0;
        end
    end

    assign w_is_ti = r_is_ti;
    assign w_tid   = r_tid;
`else
    assign w_is_ti = 1'b0;
    assign w_tid   = 32'h0;
    assign w_tcfg  = 32'h0;
    assign w_tval  = 32'h0;
`endif

    assign w_estat = {10'b0, r_ecode, 3'b000, 1'b0, w_is_ti, 1'b0, r_is_hw, r_is_sw};

    always_comb begin
        w_save_rd = 32'h0;
        for (int unsigned i = 0; i < SAVE_NUM; i++) begin
            if (i_rd_addr == ADDR_SAVE0 + 14'(i)) begin
                w_save_rd = r_save[i];
            end
        end
    end

    always_comb begin
        w_rd_data = 32'h0;
        case (i_rd_addr)
            ADDR_CRMD:   w_rd_data = r_crmd;
            ADDR_PRMD:   w_rd_data = r_prmd;
            ADDR_ECFG:   w_rd_data = r_ecfg;
            ADDR_ESTAT:  w_rd_data = w_estat;
            ADDR_ERA:    w_rd_data = r_era;
            ADDR_EENTRY: w_rd_data = r_eentry;
            ADDR_TID:    w_rd_data = w_tid;
            ADDR_TCFG:   w_rd_data = w_tcfg;
            ADDR_TVAL:   w_rd_data = w_tval;
            default:     w_rd_data = w_save_rd;
        endcase
    end

    assign o_rd_data     = w_rd_data;
    assign o_ex_entry    = r_eentry;
    assign o_ertn_pc     = r_era;
    assign o_cur_plv     = r_crmd[1:0];
    assign o_int_pending = r_crmd[CRMD_IE] && (|(w_estat[IS_W-1:0] & r_ecfg[IS_W-1:0]));

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: a word-level CSR model predicts every read and status output.
module tb_csr_file;

    localparam int unsigned SAVE_NUM = 4;
`ifdef CSR_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_mask;
    logic        ex_valid;
    logic [5:0]  ex_ecode;
    logic [31:0] ex_pc;
    logic        ertn_valid;
    logic [7:0]  hw_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic [1:0]  cur_plv;
    logic        int_pending;

    always #5 clk = ~clk;

    csr_file #(.SAVE_NUM(SAVE_NUM), .TID_INIT(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_wr_mask     (wr_mask),
        .i_ex_valid    (ex_valid),
        .i_ex_ecode    (ex_ecode),
        .i_ex_pc       (ex_pc),
        .i_ertn_valid  (ertn_valid),
        .i_hw_int      (hw_int),
        .o_ex_entry    (ex_entry),
        .o_ertn_pc     (ertn_pc),
        .o_cur_plv     (cur_plv),
        .o_int_pending (int_pending)
    );

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        ip;
        logic [31:0] entry;
        logic [31:0] era;
        logic [1:0]  plv;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic sb_req = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state, one word per architectural CSR
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_eentry, m_tid, m_tcfg, m_tval;
    logic [31:0] m_save [16];

    logic [13:0] addr_tab [19] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h00C, 14'h007,
                                   14'h030, 14'h031, 14'h032, 14'h033, 14'h034, 14'h03F, 14'h040,
                                   14'h041, 14'h042, 14'h044, 14'h002, 14'h043};

    task automatic model_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_eentry = 0;
        m_tid = 0; m_tcfg = 0; m_tval = 0;
        for (int i = 0; i < 16; i++) m_save[i] = 0;
    endtask

    function automatic logic [31:0] blend(input logic [31:0] old_v, input logic [31:0] wm);
        return (old_v & ~(wr_mask & wm)) | (wr_data & wr_mask & wm);
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a);
        if (a >= 14'h030 && int'(a) < 48 + int'(SAVE_NUM)) return m_save[int'(a) - 48];
        case (a)
            14'h000: return m_crmd;
            14'h001: return m_prmd;
            14'h004: return m_ecfg;
            14'h005: return m_estat;
            14'h006: return m_era;
            14'h00C: return m_eentry;
            14'h040: return TIMER ? m_tid : 32'h0;
            14'h041: return TIMER ? m_tcfg : 32'h0;
            14'h042: return TIMER ? m_tval : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_ip();
        return m_crmd[2] && (|(m_estat[12:0] & m_ecfg[12:0]));
    endfunction

    // Next architectural state from the inputs applied this cycle
    task automatic model_step();
        logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_eentry, n_tid, n_tcfg, n_tval, wc;
        logic [31:0] n_save [16];
        bit ex, er, fire;
        if (rst) begin
            model_reset();
            return;
        end
        n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_estat = m_estat; n_era = m_era;
        n_eentry = m_eentry; n_tid = m_tid; n_tcfg = m_tcfg; n_tval = m_tval; n_save = m_save;
        ex = ex_valid;
        er = ertn_valid && !ex_valid;
        fire = TIMER && m_tcfg[0] && (m_tval == 32'd1);
        if (wr_en) begin
            case (wr_addr)
                14'h000: if (!ex && !er) n_crmd = blend(m_crmd, 32'h1FF);
                14'h001: if (!ex) n_prmd = blend(m_prmd, 32'h7);
                14'h004: n_ecfg = blend(m_ecfg, 32'h1BFF);
                14'h005: if (!ex) n_estat = blend(m_estat, 32'h3);
                14'h006: if (!ex) n_era = blend(m_era, 32'hFFFF_FFFF);
                14'h00C: n_eentry = blend(m_eentry, 32'hFFFF_FFC0);
                14'h040: if (TIMER) n_tid = blend(m_tid, 32'hFFFF_FFFF);
                14'h041: if (TIMER) n_tcfg = blend(m_tcfg, 32'hFFFF_FFFF);
                14'h044: begin
                    wc = wr_data & wr_mask;
                    if (TIMER && wc[0]) n_estat[11] = 1'b0;
                end
                default: if (wr_addr >= 14'h030 && int'(wr_addr) < 48 + int'(SAVE_NUM))
                    n_save[int'(wr_addr) - 48] = blend(m_save[int'(wr_addr) - 48], 32'hFFFF_FFFF);
            endcase
        end
        n_estat[9:2] = hw_int;
        if (fire) n_estat[11] = 1'b1;
        if (TIMER && wr_en && wr_addr == 14'h041) n_tval = {n_tcfg[31:2], 2'b00};
        else if (fire) n_tval = m_tcfg[1] ? {m_tcfg[31:2], 2'b00} : 32'h0;
        else if (TIMER && m_tcfg[0] && m_tval != 0) n_tval = m_tval - 1;
        if (ex) begin
            n_crmd[2:0] = 3'b000;
            n_prmd[2:0] = m_crmd[2:0];
            n_era = ex_pc;
            n_estat[21:16] = ex_ecode;
        end else if (er) begin
            n_crmd[2:0] = m_prmd[2:0];
        end
        m_crmd = n_crmd; m_prmd = n_prmd; m_ecfg = n_ecfg; m_estat = n_estat; m_era = n_era;
        m_eentry = n_eentry; m_tid = n_tid; m_tcfg = n_tcfg; m_tval = n_tval; m_save = n_save;
    endtask

    task automatic set_idle();
        rst = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_mask = 0;
        ex_valid = 0; ex_ecode = 0; ex_pc = 0; ertn_valid = 0; hw_int = 0;
    endtask

    // Issue the currently driven inputs for one cycle; push the expected outputs if chk
    task automatic issue(input string nm, input bit chk, input bit lit,
                         input logic [31:0] lit_rd, input logic lit_ip);
        exp_t e;
        if (chk) begin
            e.name  = nm;
            e.rd    = lit ? lit_rd : model_read(rd_addr);
            e.ip    = lit ? lit_ip : model_ip();
            e.entry = m_eentry;
            e.era   = m_era;
            e.plv   = m_crmd[1:0];
            sb_q.push_back(e);
        end
        sb_req = chk;
        model_step();
        @(posedge clk);
        #1;
        sb_req = 1'b0;
        set_idle();
    endtask

    task automatic lit(input string nm, input logic [13:0] a, input logic [31:0] v, input logic ip);
        rd_addr = a;
        issue(nm, 1'b1, 1'b1, v, ip);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    endtask

    function automatic logic [13:0] pick();
        int k;
        k = int'($urandom_range(0, 19));
        if (k == 19) return 14'($urandom);
        return addr_tab[k];
    endfunction

    task automatic check(input string nm, input string field, input logic [31:0] act,
                         input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb_req) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: output presented with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                check(mon_e.name, "rd_data", rd_data, mon_e.rd);
                check(mon_e.name, "int_pending", 32'(int_pending), 32'(mon_e.ip));
                check(mon_e.name, "ex_entry", ex_entry, mon_e.entry);
                check(mon_e.name, "ertn_pc", ertn_pc, mon_e.era);
                check(mon_e.name, "cur_plv", 32'(cur_plv), 32'(mon_e.plv));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            issue("reset", 1'b0, 1'b0, 0, 0);
        end

        lit("rst_crmd", 14'h000, 32'h8, 1'b0);
        lit("rst_unmapped", 14'h007, 32'h0, 1'b0);
        lit("rst_save4", 14'h034, 32'h0, 1'b0);
        lit("rst_estat", 14'h005, 32'h0, 1'b0);

        wr(14'h000, 32'h7, 32'hFFFF_FFFF);
        issue("wr_crmd", 1'b1, 1'b0, 0, 0);
        lit("crmd_w", 14'h000, 32'h7, 1'b0);
        ex_valid = 1'b1; ex_pc = 32'h1C00_0100; ex_ecode = 6'h0B;
        issue("ex", 1'b1, 1'b0, 0, 0);
        lit("ex_crmd", 14'h000, 32'h0, 1'b0);
        lit("ex_prmd", 14'h001, 32'h7, 1'b0);
        lit("ex_era", 14'h006, 32'h1C00_0100, 1'b0);
        lit("ex_estat", 14'h005, 32'h000B_0000, 1'b0);
        ertn_valid = 1'b1;
        issue("ertn", 1'b1, 1'b0, 0, 0);
        lit("ertn_crmd", 14'h000, 32'h7, 1'b0);

        wr(14'h031, 32'hFFFF_0000, 32'hFFFF_FFFF);
        issue("wr_save1", 1'b1, 1'b0, 0, 0);
        wr(14'h031, 32'h1234_5678, 32'h0000_FFFF);
        issue("xchg_save1", 1'b1, 1'b0, 0, 0);
        lit("save1_val", 14'h031, 32'hFFFF_5678, 1'b0);
        wr(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("wr_eentry", 1'b1, 1'b0, 0, 0);
        lit("eentry_mask", 14'h00C, 32'hFFFF_FFC0, 1'b0);
        wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("wr_ecfg", 1'b1, 1'b0, 0, 0);
        lit("ecfg_mask", 14'h004, 32'h0000_1BFF, 1'b0);
        wr(14'h004, 32'h0, 32'hFFFF_FFFF);
        issue("clr_ecfg", 1'b1, 1'b0, 0, 0);

`ifdef CSR_TIMER_EN
        wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
        issue("wr_tcfg", 1'b1, 1'b0, 0, 0);
        for (int k = 8; k >= 1; k--) lit("tval_count", 14'h042, 32'(k), 1'b0);
        lit("tval_reload", 14'h042, 32'h8, 1'b0);
        lit("ti_set", 14'h005, 32'h000B_0800, 1'b0);
        wr(14'h044, 32'h1, 32'hFFFF_FFFF);
        issue("ticlr", 1'b1, 1'b0, 0, 0);
        lit("ti_clr", 14'h005, 32'h000B_0000, 1'b0);
        lit("ticlr_rd", 14'h044, 32'h0, 1'b0);
        wr(14'h004, 32'h800, 32'hFFFF_FFFF);
        issue("lie_ti", 1'b1, 1'b0, 0, 0);
        wr(14'h000, 32'h4, 32'hFFFF_FFFF);
        issue("crmd_ie", 1'b1, 1'b0, 0, 0);
        wr(14'h041, 32'h0000_0007, 32'hFFFF_FFFF);
        issue("tcfg_short", 1'b1, 1'b0, 0, 0);
        for (int k = 4; k >= 1; k--) lit("tval_short", 14'h042, 32'(k), 1'b0);
        rd_addr = 14'h005;
        ex_valid = 1'b1; ex_pc = 32'h100; ex_ecode = 6'h0;
        wr(14'h000, 32'h4, 32'hFFFF_FFFF);
        issue("ip_and_ex", 1'b1, 1'b1, 32'h000B_0800, 1'b1);
        lit("drop_crmd", 14'h000, 32'h0, 1'b0);
        lit("drop_prmd", 14'h001, 32'h4, 1'b0);
`else
        wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
        issue("wr_tcfg_off", 1'b1, 1'b0, 0, 0);
        lit("tcfg_off", 14'h041, 32'h0, 1'b0);
        lit("tval_off", 14'h042, 32'h0, 1'b0);
        lit("estat_off", 14'h005, 32'h000B_0000, 1'b0);
`endif

        wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
        issue("tcfg_again", 1'b1, 1'b0, 0, 0);
        issue("count", 1'b1, 1'b0, 0, 0);
        rst = 1'b1;
        issue("mid_rst", 1'b1, 1'b0, 0, 0);
        lit("rst_tval", 14'h042, 32'h0, 1'b0);
        lit("rst_tcfg", 14'h041, 32'h0, 1'b0);
        lit("rst_estat2", 14'h005, 32'h0, 1'b0);

        for (int c = 0; c < 1500; c++) begin
            rd_addr = pick();
            hw_int = 8'($urandom);
            rst = ($urandom_range(0, 99) < 2);
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = pick();
            wr_data = $urandom;
            if (wr_addr == 14'h041 && $urandom_range(0, 3) != 0) wr_data = $urandom_range(0, 31);
            wr_mask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            ex_valid = ($urandom_range(0, 9) == 0);
            ertn_valid = ($urandom_range(0, 9) == 0);
            ex_ecode = 6'($urandom);
            ex_pc = $urandom;
            issue("rand", 1'b1, 1'b0, 0, 0);
        end

        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter SAVE_NUM, default 4, number of SAVE scratch CSRs (legal 1..16, addresses 0x30..0x30+SAVE_NUM-1).
REQ-002 Parameter TID_INIT, default 32'h0, reset value of TID.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rd_addr  input  14  CSR read address; rd_data  output  32  read data.
REQ-006 wr_en  input  1, wr_addr  input  14, wr_data  input  32, wr_mask  input  32  csrwr/csrxchg write port (csrwr drives mask all-ones).
REQ-007 ex_valid  input  1, ex_ecode  input  6, ex_pc  input  32  exception commit.
REQ-008 ertn_valid  input  1  exception-return commit.
REQ-009 hw_int  input  8  hardware interrupt lines.
REQ-010 ex_entry  output  32 (=EENTRY), ertn_pc  output  32 (=ERA), cur_plv  output  2 (=CRMD.PLV), int_pending  output  1.

Function
REQ-011 Address map: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, SAVEn 0x30+n, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-012 Read combinational, zero latency; unmapped or SAVE index >= SAVE_NUM reads 32'h0; reserved bits read 0.
REQ-013 Write: new = (old & ~wr_mask) | (wr_data & wr_mask), applied to writable fields only; visible one cycle later, no read bypass.
REQ-014 Writable fields: CRMD PLV[1:0] IE[2] DA[3] PG[4] DATF[6:5] DATM[8:7]; PRMD PPLV[1:0] PIE[2]; ECFG LIE[12:0] excluding bit 10; ESTAT IS[1:0]; ERA all; EENTRY [31:6]; SAVEn all; TID all; TCFG all.
REQ-015 ex_valid: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=ex_pc, ESTAT.Ecode[21:16]<=ex_ecode.
REQ-016 ertn_valid (ex_valid low): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.
REQ-017 Priority same cycle: ex_valid > ertn_valid > wr_en; lower-priority write to any CSR touched by the winner is dropped; writes to untouched CSRs proceed.
REQ-018 ESTAT.IS[9:2] <= hw_int every cycle (one-cycle registered sample).
REQ-019 int_pending = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registered state.
REQ-020 TCFG: En[0], Periodic[1], InitVal[31:2]; TCFG write loads TVAL <= {new InitVal, 2'b00}.
REQ-021 While En=1 and TVAL!=0, TVAL decrements by 1 per cycle; the cycle TVAL==1: ESTAT.IS[11]<=1, TVAL<=Periodic ? {InitVal,2'b00} : 0.
REQ-022 En=0 or TVAL==0 (non-periodic): TVAL holds, no interrupt; TVAL not software-writable.
REQ-023 TICLR write with masked bit0=1 clears ESTAT.IS[11]; TICLR reads 0; timer set and clear in same cycle: set wins.
REQ-024 TCFG write coinciding with expiry: TCFG reload wins, IS[11] still set.

Reset
REQ-025 rst: CRMD=32'h8 (DA=1), TID=TID_INIT, all other CSRs and TVAL 0; rst overrides ex_valid/ertn_valid/wr_en.
REQ-026 After reset: ex_entry=0, ertn_pc=0, cur_plv=0, int_pending=0, rd_data per address.
REQ-027 rst mid-countdown: TVAL=0, En=0, IS[11]=0 next cycle.

Configuration
REQ-028 Macro CSR_TIMER_EN defined: TID/TCFG/TVAL/TICLR and IS[11] logic per REQ-020..024.
REQ-029 Macro CSR_TIMER_EN undefined: those addresses read 0, writes ignored, IS[11] constant 0, no counter flops.

Structure
REQ-030 Package csr_pkg holds CSR address constants, field bit-range constants, reset values.
REQ-031 Sub-module csr_timer (TCFG/TVAL counter, expiry pulse output) instantiated only under CSR_TIMER_EN.

Verification
REQ-032 Reset then read 0x0 -> 32'h8; read 0x7 -> 0; read 0x34 with SAVE_NUM=4 -> 0.
REQ-033 CRMD=0x7, ex_valid with ex_pc=0x1C000100, ecode=0x0B -> CRMD.PLV=0, IE=0, PRMD=0x7, ERA=0x1C000100, ESTAT[21:16]=0x0B; then ertn_valid -> CRMD[2:0]=0x7.
REQ-034 csrxchg SAVE1 old 0xFFFF0000, data 0x12345678, mask 0x0000FFFF -> SAVE1=0xFFFF5678.
REQ-035 TCFG=0x0B (InitVal=2, periodic, en) -> TVAL 8,7..1; IS[11]=1 on 8th cycle after write, TVAL reloads 8; TICLR=1 -> IS[11]=0.
REQ-036 ECFG.LIE=0x800, CRMD.IE=1, timer expires -> int_pending=1; same cycle ex_valid and wr_en to CRMD -> write dropped, IE=0, int_pending=0.
